// File: rtl/qspi_mem_ctrl.sv
// Shared quad-SPI master: serialises one CPU read/write at a time onto the
// flash/PSRAM bus (shared SCLK and IO, separate chip selects).
`timescale 1ns/1ps
module qspi_mem_ctrl #(
   parameter int FLASH_DUMMY = 8,
   parameter int PSRAM_DUMMY = 6,
   parameter int CS_HIGH_MIN = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_sel,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [23:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        flash_cs_n,
   output logic        ram_cs_n,
   output logic        sclk,
   output logic [3:0]  io_out,
   output logic [3:0]  io_oe,
   input  logic [3:0]  io_in
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, CSGAP} state_t;

   state_t      state, state_d;
   logic        phase_h, phase_h_d;
   logic [7:0]  cnt, cnt_d;
   logic [7:0]  gap, gap_d;
   logic        sel, sel_d, we, we_d;
   logic [2:0]  nbytes, nbytes_d;
   logic [7:0]  cmd, cmd_d;
   logic [23:0] addr, addr_d;
   logic [31:0] wdata, wdata_d, rdata, rdata_d;
   logic        resp_valid_d, resp_err_d, flash_cs_n_d, ram_cs_n_d, sclk_d;
   logic [31:0] resp_rdata_d;
   logic [3:0]  io_out_d, io_oe_d;
   logic [7:0]  phase_len, dummy_len;
   logic [10:0] sh;
   logic [7:0]  new_cmd;
   state_t      nxt;

   // Value driven on IO for bit/nibble i of a phase.
   function automatic logic [3:0] drive_nib(state_t s, logic [7:0] i, logic [7:0] c,
                                            logic [23:0] a, logic [31:0] w, logic wr);
      logic [7:0] b;
      drive_nib = 4'h0;
      b = 8'(w >> (32'd8 * 32'(i[7:1])));
      case (s)
         CMD:     drive_nib = {3'b000, 1'(c >> (32'd7 - 32'(i)))};
         ADDR:    drive_nib = 4'(a >> (32'd20 - 32'd4 * 32'(i)));
         DATA:    drive_nib = !wr ? 4'h0 : (i[0] ? b[3:0] : b[7:4]);
         default: drive_nib = 4'h0;
      endcase
   endfunction

   function automatic logic [3:0] oe_for(state_t s, logic wr);
      case (s)
         CMD:     oe_for = 4'b0001;
         ADDR:    oe_for = 4'b1111;
         DATA:    oe_for = wr ? 4'b1111 : 4'b0000;
         default: oe_for = 4'b0000;
      endcase
   endfunction

   assign req_ready = (state == IDLE);

   always_comb begin
      dummy_len = sel ? 8'(PSRAM_DUMMY) : 8'(FLASH_DUMMY);
      case (state)
         CMD:     phase_len = 8'd8;
         ADDR:    phase_len = 8'd6;
         DUMMY:   phase_len = dummy_len;
         DATA:    phase_len = {4'b0000, nbytes, 1'b0};
         default: phase_len = 8'd1;
      endcase
   end

   always_comb begin
      state_d      = state;
      phase_h_d    = phase_h;
      cnt_d        = cnt;
      gap_d        = gap;
      sel_d        = sel;
      we_d         = we;
      nbytes_d     = nbytes;
      cmd_d        = cmd;
      addr_d       = addr;
      wdata_d      = wdata;
      rdata_d      = rdata;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err;
      resp_rdata_d = resp_rdata;
      flash_cs_n_d = flash_cs_n;
      ram_cs_n_d   = ram_cs_n;
      sclk_d       = sclk;
      io_out_d     = io_out;
      io_oe_d      = io_oe;
      new_cmd      = req_we ? 8'h38 : 8'hEB;
      nxt          = IDLE;
      sh           = {1'b0, cnt[7:1], 3'b000} + (cnt[0] ? 11'd0 : 11'd4);
      case (state)
         IDLE: if (req_valid) begin
            if (!req_sel && req_we) begin
               // flash is read-only: reject without touching the bus
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end else begin
               sel_d        = req_sel;
               we_d         = req_we;
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               cmd_d        = new_cmd;
               nbytes_d     = (req_size == 2'd0) ? 3'd1 : (req_size == 2'd1) ? 3'd2 : 3'd4;
               rdata_d      = 32'h0;
               cnt_d        = 8'd0;
               phase_h_d    = 1'b0;
               sclk_d       = 1'b0;
               flash_cs_n_d = req_sel;
               ram_cs_n_d   = !req_sel;
               io_out_d     = {3'b000, new_cmd[7]};
               io_oe_d      = 4'b0001;
               state_d      = CMD;
            end
         end
         CMD, ADDR, DUMMY, DATA: begin
            if (!phase_h) begin
               sclk_d    = 1'b1;
               phase_h_d = 1'b1;
            end else begin
               sclk_d    = 1'b0;
               phase_h_d = 1'b0;
               if (state == DATA && !we)
                  rdata_d = rdata | (32'(io_in) << sh);
               if (cnt != phase_len - 8'd1) begin
                  cnt_d    = cnt + 8'd1;
                  io_out_d = drive_nib(state, cnt + 8'd1, cmd, addr, wdata, we);
               end else begin
                  cnt_d = 8'd0;
                  case (state)
                     CMD:     nxt = ADDR;
                     ADDR:    nxt = (we || dummy_len == 8'd0) ? DATA : DUMMY;
                     DUMMY:   nxt = DATA;
                     default: nxt = CSGAP;
                  endcase
                  if (nxt == CSGAP) begin
                     flash_cs_n_d = 1'b1;
                     ram_cs_n_d   = 1'b1;
                     io_out_d     = 4'h0;
                     io_oe_d      = 4'h0;
                     resp_valid_d = 1'b1;
                     resp_err_d   = 1'b0;
                     if (!we) resp_rdata_d = rdata_d;
                     gap_d        = 8'd0;
                     state_d      = (CS_HIGH_MIN > 1) ? CSGAP : IDLE;
                  end else begin
                     io_out_d = drive_nib(nxt, 8'd0, cmd, addr, wdata, we);
                     io_oe_d  = oe_for(nxt, we);
                     state_d  = nxt;
                  end
               end
            end
         end
         CSGAP: begin
            // the IDLE cycle itself is the last CS-high cycle before the next accept
            if (int'(gap) + 2 >= CS_HIGH_MIN) state_d = IDLE;
            else gap_d = gap + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         phase_h    <= 1'b0;
         cnt        <= 8'd0;
         gap        <= 8'd0;
         sel        <= 1'b0;
         we         <= 1'b0;
         nbytes     <= 3'd0;
         cmd        <= 8'h0;
         addr       <= 24'h0;
         wdata      <= 32'h0;
         rdata      <= 32'h0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         flash_cs_n <= 1'b1;
         ram_cs_n   <= 1'b1;
         sclk       <= 1'b0;
         io_out     <= 4'h0;
         io_oe      <= 4'h0;
      end else begin
         state      <= state_d;
         phase_h    <= phase_h_d;
         cnt        <= cnt_d;
         gap        <= gap_d;
         sel        <= sel_d;
         we         <= we_d;
         nbytes     <= nbytes_d;
         cmd        <= cmd_d;
         addr       <= addr_d;
         wdata      <= wdata_d;
         rdata      <= rdata_d;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         resp_rdata <= resp_rdata_d;
         flash_cs_n <= flash_cs_n_d;
         ram_cs_n   <= ram_cs_n_d;
         sclk       <= sclk_d;
         io_out     <= io_out_d;
         io_oe      <= io_oe_d;
      end
   end

endmodule
